// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: steers the fetch PC mux and captures each fetched
// word, tagged with its PC, into the IF/ID latch.
module fetch_ctrl #(
  parameter logic [15:0] INIT_PC     = 16'h0000,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] inst_code,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [1:0]  sel_pc,
  output logic        enable_pc,
  output logic [15:0] branch_pc,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_INIT   = 2'b00;
  localparam logic [1:0] SEL_INC    = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;

  state_t      state_reg;
  logic [15:0] shadow_pc_reg;

  assign branch_pc = branch_target;

  always_comb begin
    sel_pc    = SEL_INC;
    enable_pc = 1'b0;
    unique case (state_reg)
      BOOT: begin
        sel_pc    = SEL_INIT;
        enable_pc = 1'b1;
      end
      RUN: begin
        if (branch_taken) begin
          sel_pc    = SEL_BRANCH;
          enable_pc = 1'b1;
        end else if (stall) begin
          enable_pc = 1'b0;
        end else if (inst_code == HALT_OPCODE) begin
          enable_pc = 1'b0;
        end else begin
          enable_pc = 1'b1;
        end
      end
      HALT: begin
        if (branch_taken) begin
          sel_pc    = SEL_BRANCH;
          enable_pc = 1'b1;
        end
      end
      default: begin
        sel_pc    = SEL_INC;
        enable_pc = 1'b0;
      end
    endcase
  end

  // shadow_pc_reg mirrors the fetch PC so each captured word carries its address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= BOOT;
      shadow_pc_reg <= INIT_PC;
      ifid_inst     <= 16'h0000;
      ifid_pc       <= INIT_PC;
      ifid_valid    <= 1'b0;
      halted        <= 1'b0;
    end else begin
      unique case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          if (branch_taken) begin
            shadow_pc_reg <= branch_target;
            ifid_valid    <= 1'b0;
          end else if (!stall) begin
            ifid_inst  <= inst_code;
            ifid_pc    <= shadow_pc_reg;
            ifid_valid <= 1'b1;
            if (inst_code == HALT_OPCODE) begin
              state_reg <= HALT;
              halted    <= 1'b1;
            end else begin
              shadow_pc_reg <= shadow_pc_reg + 16'd1;
            end
          end
        end
        HALT: begin
          if (branch_taken) begin
            shadow_pc_reg <= branch_target;
            ifid_valid    <= 1'b0;
            halted        <= 1'b0;
            state_reg     <= RUN;
          end else if (!stall) begin
            // the halt word has been consumed downstream
            ifid_valid <= 1'b0;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: two instances (boot at 0010 and at FFFF),
// each paired with a small fetch PC register and instruction memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;

  logic [15:0] a_inst_code, a_branch_pc, a_ifid_inst, a_ifid_pc, a_fetch_pc;
  logic [1:0]  a_sel_pc;
  logic        a_enable_pc, a_ifid_valid, a_halted;
  logic [15:0] b_inst_code, b_branch_pc, b_ifid_inst, b_ifid_pc, b_fetch_pc;
  logic [1:0]  b_sel_pc;
  logic        b_enable_pc, b_ifid_valid, b_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory image: 0005 holds the halt word, otherwise A000 + (addr - 000F)
  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    if (addr == 16'h0005) return 16'hFFFF;
    return 16'hA000 + (addr - 16'h000F);
  endfunction

  assign a_inst_code = mem_word(a_fetch_pc);
  assign b_inst_code = mem_word(b_fetch_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) a_fetch_pc <= 16'h0010;
    else if (a_enable_pc) begin
      case (a_sel_pc)
        2'b00:   a_fetch_pc <= 16'h0010;
        2'b01:   a_fetch_pc <= a_fetch_pc + 16'd1;
        2'b10:   a_fetch_pc <= a_branch_pc;
        default: a_fetch_pc <= 16'hDEAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) b_fetch_pc <= 16'hFFFF;
    else if (b_enable_pc) begin
      case (b_sel_pc)
        2'b00:   b_fetch_pc <= 16'hFFFF;
        2'b01:   b_fetch_pc <= b_fetch_pc + 16'd1;
        2'b10:   b_fetch_pc <= b_branch_pc;
        default: b_fetch_pc <= 16'hDEAD;
      endcase
    end
  end

  fetch_ctrl #(.INIT_PC(16'h0010), .HALT_OPCODE(16'hFFFF)) dut_a (
    .clk(clk), .reset(reset), .inst_code(a_inst_code), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .sel_pc(a_sel_pc), .enable_pc(a_enable_pc), .branch_pc(a_branch_pc),
    .ifid_inst(a_ifid_inst), .ifid_pc(a_ifid_pc), .ifid_valid(a_ifid_valid),
    .halted(a_halted)
  );

  fetch_ctrl #(.INIT_PC(16'hFFFF), .HALT_OPCODE(16'hFFFF)) dut_b (
    .clk(clk), .reset(reset), .inst_code(b_inst_code), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .sel_pc(b_sel_pc), .enable_pc(b_enable_pc), .branch_pc(b_branch_pc),
    .ifid_inst(b_ifid_inst), .ifid_pc(b_ifid_pc), .ifid_valid(b_ifid_valid),
    .halted(b_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (a_ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", a_ifid_valid); end
    n_checks++; if (a_ifid_pc !== 16'h0010) begin n_fail++; $display("FAIL reset_pc: got %h expected 0010", a_ifid_pc); end
    n_checks++; if (a_ifid_inst !== 16'h0000) begin n_fail++; $display("FAIL reset_inst: got %h expected 0000", a_ifid_inst); end
    n_checks++; if (a_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", a_halted); end
    n_checks++; if (a_sel_pc !== 2'b00 || a_enable_pc !== 1'b1) begin n_fail++; $display("FAIL reset_boot_sel: got sel=%b en=%b expected sel=00 en=1", a_sel_pc, a_enable_pc); end
    n_checks++; if (b_ifid_pc !== 16'hFFFF) begin n_fail++; $display("FAIL reset_pc_b: got %h expected ffff", b_ifid_pc); end
    $display("test_reset: ifid=(%h,%h,v=%b) halted=%b", a_ifid_inst, a_ifid_pc, a_ifid_valid, a_halted);
  endtask

  task automatic test_boot();
    reset = 1'b1;
    #1;
    n_checks++; if (a_sel_pc !== 2'b00) begin n_fail++; $display("FAIL boot_sel: got %b expected 00", a_sel_pc); end
    tick();
    n_checks++; if (a_sel_pc !== 2'b01 || a_enable_pc !== 1'b1) begin n_fail++; $display("FAIL run_sel: got sel=%b en=%b expected sel=01 en=1", a_sel_pc, a_enable_pc); end
    n_checks++; if (a_ifid_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", a_ifid_valid); end
    tick();
    n_checks++; if (a_ifid_inst !== 16'hA001 || a_ifid_pc !== 16'h0010 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL boot_cap1: got (%h,%h,%b) expected (a001,0010,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    tick();
    n_checks++; if (a_ifid_inst !== 16'hA002 || a_ifid_pc !== 16'h0011 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL boot_cap2: got (%h,%h,%b) expected (a002,0011,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    $display("test_boot: ifid=(%h,%h,v=%b)", a_ifid_inst, a_ifid_pc, a_ifid_valid);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    n_checks++; if (a_enable_pc !== 1'b0) begin n_fail++; $display("FAIL stall_en: got %b expected 0", a_enable_pc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (a_enable_pc !== 1'b0) begin n_fail++; $display("FAIL stall_en_%0d: got %b expected 0", i, a_enable_pc); end
      n_checks++; if (a_ifid_inst !== 16'hA002 || a_ifid_pc !== 16'h0011 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_%0d: got (%h,%h,%b) expected (a002,0011,1)", i, a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (a_ifid_inst !== 16'hA003 || a_ifid_pc !== 16'h0012 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got (%h,%h,%b) expected (a003,0012,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    $display("test_stall: ifid=(%h,%h,v=%b)", a_ifid_inst, a_ifid_pc, a_ifid_valid);
  endtask

  task automatic test_branch_stall();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    #1;
    n_checks++; if (a_sel_pc !== 2'b10 || a_enable_pc !== 1'b1 || a_branch_pc !== 16'h0040) begin n_fail++; $display("FAIL branch_ctl: got sel=%b en=%b bpc=%h expected sel=10 en=1 bpc=0040", a_sel_pc, a_enable_pc, a_branch_pc); end
    tick();
    n_checks++; if (a_ifid_valid !== 1'b0) begin n_fail++; $display("FAIL branch_squash: got %b expected 0", a_ifid_valid); end
    branch_taken = 1'b0;
    stall = 1'b0;
    tick();
    n_checks++; if (a_ifid_inst !== 16'hA031 || a_ifid_pc !== 16'h0040 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL branch_target_cap: got (%h,%h,%b) expected (a031,0040,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    $display("test_branch_stall: ifid=(%h,%h,v=%b)", a_ifid_inst, a_ifid_pc, a_ifid_valid);
  endtask

  task automatic test_halt();
    branch_taken = 1'b1;
    branch_target = 16'h0005;
    tick();
    branch_taken = 1'b0;
    #1;
    n_checks++; if (a_enable_pc !== 1'b0) begin n_fail++; $display("FAIL halt_word_en: got %b expected 0", a_enable_pc); end
    tick();
    n_checks++; if (a_ifid_inst !== 16'hFFFF || a_ifid_pc !== 16'h0005 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL halt_cap: got (%h,%h,%b) expected (ffff,0005,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    n_checks++; if (a_halted !== 1'b1 || a_enable_pc !== 1'b0 || a_sel_pc !== 2'b01) begin n_fail++; $display("FAIL halt_state: got halted=%b en=%b sel=%b expected 1,0,01", a_halted, a_enable_pc, a_sel_pc); end
    stall = 1'b1;
    tick();
    n_checks++; if (a_ifid_valid !== 1'b1 || a_halted !== 1'b1) begin n_fail++; $display("FAIL halt_stall_hold: got v=%b halted=%b expected 1,1", a_ifid_valid, a_halted); end
    stall = 1'b0;
    tick();
    n_checks++; if (a_ifid_valid !== 1'b0 || a_ifid_pc !== 16'h0005 || a_halted !== 1'b1) begin n_fail++; $display("FAIL halt_consume: got v=%b pc=%h halted=%b expected 0,0005,1", a_ifid_valid, a_ifid_pc, a_halted); end
    tick();
    n_checks++; if (a_fetch_pc !== 16'h0005 || a_ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_frozen: got fetch_pc=%h v=%b expected 0005,0", a_fetch_pc, a_ifid_valid); end
    $display("test_halt: ifid=(%h,%h,v=%b) halted=%b", a_ifid_inst, a_ifid_pc, a_ifid_valid, a_halted);
  endtask

  task automatic test_halt_branch();
    branch_taken = 1'b1;
    branch_target = 16'h0020;
    #1;
    n_checks++; if (a_sel_pc !== 2'b10 || a_enable_pc !== 1'b1 || a_halted !== 1'b1) begin n_fail++; $display("FAIL halt_branch_ctl: got sel=%b en=%b halted=%b expected 10,1,1", a_sel_pc, a_enable_pc, a_halted); end
    tick();
    branch_taken = 1'b0;
    n_checks++; if (a_halted !== 1'b0 || a_ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_branch_exit: got halted=%b v=%b expected 0,0", a_halted, a_ifid_valid); end
    #1;
    n_checks++; if (a_sel_pc !== 2'b01 || a_enable_pc !== 1'b1) begin n_fail++; $display("FAIL halt_branch_run: got sel=%b en=%b expected 01,1", a_sel_pc, a_enable_pc); end
    tick();
    n_checks++; if (a_ifid_inst !== 16'hA011 || a_ifid_pc !== 16'h0020 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL halt_branch_cap: got (%h,%h,%b) expected (a011,0020,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    $display("test_halt_branch: ifid=(%h,%h,v=%b)", a_ifid_inst, a_ifid_pc, a_ifid_valid);
  endtask

  task automatic test_reset_mid_run();
    tick();
    n_checks++; if (a_ifid_pc !== 16'h0021 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_cap: got pc=%h v=%b expected 0021,1", a_ifid_pc, a_ifid_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (a_ifid_valid !== 1'b0 || a_halted !== 1'b0 || a_ifid_pc !== 16'h0010) begin n_fail++; $display("FAIL async_reset: got v=%b halted=%b pc=%h expected 0,0,0010", a_ifid_valid, a_halted, a_ifid_pc); end
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (a_sel_pc !== 2'b00) begin n_fail++; $display("FAIL rst_boot_sel: got %b expected 00", a_sel_pc); end
    tick();
    n_checks++; if (a_sel_pc !== 2'b01) begin n_fail++; $display("FAIL rst_boot_once: got %b expected 01", a_sel_pc); end
    tick();
    n_checks++; if (a_ifid_inst !== 16'hA001 || a_ifid_pc !== 16'h0010 || a_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL rst_refetch: got (%h,%h,%b) expected (a001,0010,1)", a_ifid_inst, a_ifid_pc, a_ifid_valid); end
    $display("test_reset_mid_run: ifid=(%h,%h,v=%b)", a_ifid_inst, a_ifid_pc, a_ifid_valid);
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (b_ifid_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_boot: got v=%b expected 0", b_ifid_valid); end
    tick();
    n_checks++; if (b_ifid_inst !== 16'h9FF0 || b_ifid_pc !== 16'hFFFF || b_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_cap1: got (%h,%h,%b) expected (9ff0,ffff,1)", b_ifid_inst, b_ifid_pc, b_ifid_valid); end
    tick();
    n_checks++; if (b_ifid_inst !== 16'h9FF1 || b_ifid_pc !== 16'h0000 || b_ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_cap2: got (%h,%h,%b) expected (9ff1,0000,1)", b_ifid_inst, b_ifid_pc, b_ifid_valid); end
    $display("test_wrap: ifid=(%h,%h,v=%b)", b_ifid_inst, b_ifid_pc, b_ifid_valid);
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_branch_stall();
    test_halt();
    test_halt_branch();
    test_reset_mid_run();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
